apuf_challenge_ctrl: RTL and testbench
======================================

# apuf_challenge_ctrl

Challenge-issuing and response-collecting controller for the 37-stage arbiter PUF. On a start request it drives a sequence of LFSR-generated challenges, fires the race by toggling the shared launch line into the PUF's X/Y inputs, and samples the PUF's one-bit arbiter output. It majority-votes repeated evaluations per challenge, packs the voted bits into a response word, and hands the word off over a valid/ready handshake. The block sits between the PUF instance and the system-side consumer (key extractor / UART dump).

## Interface
Parameters:
- CHAL_W, 37, challenge width; must match the PUF stage count.
- NUM_BITS, 32, voted response bits per word.
- REPEATS, 5, evaluations per challenge; odd, 1..15.
- SETTLE, 8, cycles per launch phase; ≥4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a new word; sampled only in IDLE.
- seed  in  CHAL_W  initial LFSR value, captured with start.
- chal_out  out  CHAL_W  challenge to the PUF Chal bus.
- launch  out  1  drives the PUF X and Y inputs together.
- puf_resp  in  1  PUF arbiter output, asynchronous to clk.
- busy  out  1  high in every state except IDLE.
- resp_word  out  NUM_BITS  collected response.
- resp_valid  out  1  resp_word is valid.
- resp_ready  in  1  consumer accepts the word.

## Operation
- puf_resp passes through a 2-flop synchronizer; only the synchronized value is used.
- Operating cycle: IDLE -> PRE -> FIRE -> SAMPLE -> (PRE | OUT) -> IDLE.
- IDLE: when start=1, load LFSR with seed (seed==0 loads 1), clear the word, vote count, repeat count and bit count, and go to PRE.
- PRE: launch=0 for SETTLE cycles so the PUF paths discharge.
- FIRE: launch=1 for SETTLE cycles; the race resolves inside the PUF.
- SAMPLE, 1 cycle: launch=0; add the synchronized response to ones_cnt; increment rep_cnt.
  - If rep_cnt < REPEATS, go to PRE.
  - Otherwise voted bit = (ones_cnt > REPEATS/2); shift it into resp_word LSB (word <= {word[NUM_BITS-2:0], bit}); clear ones_cnt and rep_cnt; step the LFSR; increment bit_cnt.
  - Then go to PRE, or to OUT once bit_cnt reaches NUM_BITS.
- LFSR step: fb = c[36]^c[4]^c[3]^c[2]^c[1]^c[0]; next = {c[35:0], fb}. This is the CHAL_W=37 polynomial.
- chal_out = LFSR register. It is held constant through every PRE/FIRE/SAMPLE of one bit.
- OUT: resp_valid=1, resp_word held stable. When resp_ready=1, go to IDLE and drop resp_valid on the next cycle.
- Bit order: the first challenge's voted bit ends in resp_word[NUM_BITS-1].
- start outside IDLE is ignored.
- resp_word keeps its last value in IDLE until the next start clears it.

## Timing
- Reset values: launch=0, chal_out=0, busy=0, resp_valid=0, resp_word=0; state IDLE; all counters 0; synchronizer 0.
- Reset mid-operation forces these values immediately (asynchronously). No partial word is emitted.
- start high at cycle t (IDLE): PRE begins at t+1, and chal_out=seed at t+1.
- Each evaluation is 2·SETTLE+1 cycles. Launch rises at the first FIRE cycle and falls on entry to SAMPLE.
- resp_valid first high at t + NUM_BITS·REPEATS·(2·SETTLE+1) + 1. With defaults this is t+2721.
- Handshake completes on a cycle with resp_valid=1 and resp_ready=1. resp_valid=0 and busy=0 on the following cycle.
- resp_ready held high before OUT: the word is transferred in the first OUT cycle (resp_valid high for exactly 1 cycle).
- start high in the same cycle that OUT is left: not accepted, because the state is not yet IDLE.

## Test plan
- Reset: drive rst=1 mid-FIRE with launch=1 → launch, busy, resp_valid and chal_out go 0 without waiting for a clk edge; after release the block is idle and start works normally.
- Seed/LFSR: seed=1, PUF stub returns chal_out[0] → chal_out=1 for the first bit and 3 for the second; resp_word[31]=1; the full word matches the software LFSR model.
- Zero seed: seed=0 → chal_out=1 in the first PRE; the sequence is identical to the seed=1 run.
- Majority vote: REPEATS=5, stub pattern 1,1,0,0,1 → voted bit 1; pattern 0,0,1,1,0 → voted bit 0; pattern 1,1,1,0,0 with REPEATS=3 truncated to the first 3 evaluations → 1.
- Launch timing: defaults, start at cycle 10 → launch high during cycles 19–26 and low at 27; resp_valid first high at cycle 2731.
- Backpressure: hold resp_ready=0 for 20 cycles in OUT and pulse start → resp_valid and resp_word stay stable and start is ignored; resp_ready=1 → resp_valid=0 next cycle, then a new start is accepted.

Source files
------------

// File: rtl/apuf_challenge_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apuf_challenge_ctrl_if : response-word valid/ready handoff to the consumer
// Revision 1.0
// ---------------------------------------------------------------------------
interface apuf_challenge_ctrl_if #(
  parameter int NUM_BITS = 32
);
  logic [NUM_BITS-1:0] resp_word;
  logic                resp_valid;
  logic                resp_ready;

  modport master (output resp_word, output resp_valid, input resp_ready);
  modport slave  (input resp_word, input resp_valid, output resp_ready);
endinterface
`default_nettype wire

// File: rtl/apuf_challenge_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apuf_challenge_ctrl : arbiter-PUF challenge issue, majority vote, word pack
// Revision 1.0
// ---------------------------------------------------------------------------
module apuf_challenge_ctrl #(
  parameter int CHAL_W   = 37,
  parameter int NUM_BITS = 32,
  parameter int REPEATS  = 5,
  parameter int SETTLE   = 8
) (
  input  wire                clk,
  input  wire                rst,
  input  wire                start,
  input  wire [CHAL_W-1:0]   seed,
  output logic [CHAL_W-1:0]  chal_out,
  output logic               launch,
  input  wire                puf_resp,
  output logic               busy,
  apuf_challenge_ctrl_if.master resp
);

  localparam int PH_W  = $clog2(SETTLE);
  localparam int CNT_W = $clog2(REPEATS + 1);
  localparam int BIT_W = $clog2(NUM_BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    FIRE   = 3'd2,
    SAMPLE = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [PH_W-1:0]     phase;
  logic [1:0]          sync;
  logic [CHAL_W-1:0]   lfsr;
  logic [CHAL_W-1:0]   lfsr_next;
  logic [NUM_BITS-1:0] word;
  logic [CNT_W-1:0]    ones_cnt, ones_n;
  logic [CNT_W-1:0]    rep_cnt, rep_n;
  logic [BIT_W-1:0]    bit_cnt;
  logic                phase_done;
  logic                last_rep;
  logic                last_bit;
  logic                voted;

  // Taps c[36]^c[4]^c[3]^c[2]^c[1]^c[0] for the 37-stage polynomial
  assign lfsr_next = {lfsr[CHAL_W-2:0],
                      lfsr[CHAL_W-1] ^ lfsr[4] ^ lfsr[3] ^ lfsr[2] ^ lfsr[1] ^ lfsr[0]};

  assign chal_out       = lfsr;
  assign resp.resp_word = word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n         = state;
    busy            = (state != IDLE);
    resp.resp_valid = (state == OUT);
    phase_done      = (phase == PH_W'(SETTLE - 1));
    ones_n          = ones_cnt + CNT_W'(sync[1]);
    rep_n           = rep_cnt + CNT_W'(1);
    last_rep        = (rep_n == CNT_W'(REPEATS));
    last_bit        = (bit_cnt == BIT_W'(NUM_BITS - 1));
    voted           = (ones_n > CNT_W'(REPEATS / 2));
    case (state)
      IDLE:    if (start) state_n = PRE;
      PRE:     if (phase_done) state_n = FIRE;
      FIRE:    if (phase_done) state_n = SAMPLE;
      SAMPLE:  state_n = (last_rep && last_bit) ? OUT : PRE;
      OUT:     if (resp.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // launch is registered from the next state so the PUF sees a glitch-free edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      launch   <= 1'b0;
      phase    <= '0;
      lfsr     <= '0;
      word     <= '0;
      ones_cnt <= '0;
      rep_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      sync   <= {sync[0], puf_resp};
      launch <= (state_n == FIRE);
      phase  <= ((state_n == state) && (state == PRE || state == FIRE)) ?
                phase + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (start) begin
            lfsr     <= (seed == '0) ? CHAL_W'(1) : seed;
            word     <= '0;
            ones_cnt <= '0;
            rep_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        SAMPLE: begin
          if (last_rep) begin
            word     <= {word[NUM_BITS-2:0], voted};
            ones_cnt <= '0;
            rep_cnt  <= '0;
            lfsr     <= lfsr_next;
            bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            ones_cnt <= ones_n;
            rep_cnt  <= rep_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apuf_challenge_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apuf_challenge_ctrl : directed bench with a behavioural PUF stub
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_apuf_challenge_ctrl;

  localparam int CHAL_W = 37;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CHAL_W-1:0] seed = '0;
  logic [CHAL_W-1:0] chal_out;
  logic              launch;
  logic              puf_resp = 1'b0;
  logic              busy;

  logic              start2 = 1'b0;
  logic [CHAL_W-1:0] seed2 = 37'd1;
  logic [CHAL_W-1:0] chal_out2;
  logic              launch2;
  logic              puf_resp2 = 1'b0;
  logic              busy2;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int ev_cnt = 0;
  int ev2    = 0;

  logic [17:0]       lvec;
  logic [17:0]       lexp;
  logic [CHAL_W-1:0] c1, c2;
  logic [31:0]       w;
  int                lat;

  bit pat_a [5] = '{1, 1, 0, 0, 1};
  bit pat_b [5] = '{0, 0, 1, 1, 0};
  bit pat_s [5] = '{1, 1, 1, 0, 0};

  apuf_challenge_ctrl_if #(.NUM_BITS(32)) resp_if ();
  apuf_challenge_ctrl_if #(.NUM_BITS(4))  resp_if2 ();

  apuf_challenge_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .chal_out(chal_out),
    .launch(launch), .puf_resp(puf_resp), .busy(busy), .resp(resp_if)
  );

  apuf_challenge_ctrl #(.CHAL_W(37), .NUM_BITS(4), .REPEATS(3), .SETTLE(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .seed(seed2), .chal_out(chal_out2),
    .launch(launch2), .puf_resp(puf_resp2), .busy(busy2), .resp(resp_if2)
  );

  always #5 clk = ~clk;

  // PUF stubs: a new response is presented at each launch rising edge
  always @(posedge launch) begin
    if (mode == 0) puf_resp = chal_out[0];
    else puf_resp = ((ev_cnt / 5) % 2 == 0) ? pat_a[ev_cnt % 5] : pat_b[ev_cnt % 5];
    ev_cnt = ev_cnt + 1;
  end

  always @(posedge launch2) begin
    puf_resp2 = pat_s[ev2 % 5];
    ev2 = ev2 + 1;
  end

  function automatic logic [CHAL_W-1:0] lfsr_step(input logic [CHAL_W-1:0] c);
    return {c[35:0], c[36] ^ c[4] ^ c[3] ^ c[2] ^ c[1] ^ c[0]};
  endfunction

  function automatic logic [31:0] model_word(input logic [CHAL_W-1:0] s);
    logic [CHAL_W-1:0] c;
    logic [31:0]       r;
    c = (s == '0) ? 37'd1 : s;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r = {r[30:0], c[0]};
      c = lfsr_step(c);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns once resp_valid is seen or the budget expires
  task automatic run_word(input logic [CHAL_W-1:0] s);
    seed  = s;
    start = 1'b1;
    lvec  = '0;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    c1    = chal_out;
    lvec[1] = launch;
    while (resp_if.resp_valid !== 1'b1 && lat < 4000) begin
      @(negedge clk);
      lat++;
      if (lat <= 17) lvec[lat] = launch;
      if (lat == 86) c2 = chal_out;
    end
    w = resp_if.resp_word;
  endtask

  initial begin
    logic [31:0] w_hold;
    bit          stable;
    int          lat2;
    int          k;

    for (int i = 0; i < 18; i++) lexp[i] = (i >= 9 && i <= 16);
    resp_if.resp_ready  = 1'b1;
    resp_if2.resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_launch", launch, 1'b0);
    check("rst_chal",   chal_out, 37'd0);
    check("rst_busy",   busy, 1'b0);
    check("rst_valid",  resp_if.resp_valid, 1'b0);
    check("rst_word",   resp_if.resp_word, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // seed = 1, stub returns chal_out[0], consumer always ready
    mode = 0; ev_cnt = 0;
    run_word(37'd1);
    check("seed1_chal_bit0", c1, 37'd1);
    check("seed1_chal_bit1", c2, 37'd3);
    check("launch_window",   lvec, lexp);
    check("valid_latency",   lat, 2721);
    check("seed1_msb",       w[31], 1'b1);
    check("seed1_word",      w, model_word(37'd1));
    @(negedge clk);
    check("valid_one_cycle", resp_if.resp_valid, 1'b0);
    check("idle_after_xfer", busy, 1'b0);

    // zero seed behaves as seed 1
    mode = 0; ev_cnt = 0;
    run_word(37'd0);
    check("seed0_chal_bit0", c1, 37'd1);
    check("seed0_word",      w, model_word(37'd1));
    @(negedge clk);

    // majority vote: alternating 1,1,0,0,1 / 0,0,1,1,0 per bit
    mode = 1; ev_cnt = 0;
    run_word(37'd5);
    check("vote_word", w, 32'hAAAA_AAAA);
    @(negedge clk);

    // REPEATS=3 instance consumes the repeating stream 1,1,1,0,0
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat2 = 1;
    while (resp_if2.resp_valid !== 1'b1 && lat2 < 500) begin
      @(negedge clk);
      lat2++;
    end
    check("r3_latency", lat2, 109);
    check("r3_word",    resp_if2.resp_word, 4'hB);
    @(negedge clk);

    // backpressure: consumer stalls for 20 cycles while start is pulsed
    mode = 0; ev_cnt = 0;
    resp_if.resp_ready = 1'b0;
    run_word(37'h1_2345_6789);
    check("bp_word", w, model_word(37'h1_2345_6789));
    w_hold = w;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i == 10);
      @(negedge clk);
      if (resp_if.resp_valid !== 1'b1 || resp_if.resp_word !== w_hold) stable = 1'b0;
    end
    start = 1'b0;
    check("bp_stable", stable, 1'b1);
    check("bp_busy",   busy, 1'b1);

    // handshake with start held: not taken on the leaving edge, taken on the next
    resp_if.resp_ready = 1'b1;
    seed  = 37'd5;
    start = 1'b1;
    @(negedge clk);
    check("hs_valid_drop", resp_if.resp_valid, 1'b0);
    check("hs_busy_drop",  busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", busy, 1'b1);
    check("restart_chal", chal_out, 37'd5);

    // asynchronous reset in the middle of FIRE
    k = 0;
    while (launch !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("fire_reached", launch, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_launch", launch, 1'b0);
    check("arst_busy",   busy, 1'b0);
    check("arst_valid",  resp_if.resp_valid, 1'b0);
    check("arst_chal",   chal_out, 37'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);
    seed  = 37'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_busy", busy, 1'b1);
    check("post_rst_chal", chal_out, 37'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
